// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: FIFO read port to valid/ready stream adapter with a 2-entry skid buffer.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 18,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  CLK_i,
    input  logic                  RST_i,
    input  logic                  FLUSH_i,
    input  logic                  EMPTY_i,
    input  logic                  UNDERRUN_i,
    input  logic [DATA_WIDTH-1:0] RDATA_i,
    output logic                  REN_o,
    output logic                  M_VALID_o,
    input  logic                  M_READY_i,
    output logic [DATA_WIDTH-1:0] M_DATA_o,
    output logic [CNT_WIDTH-1:0]  WORD_CNT_o,
    output logic                  ERR_o
);
    logic [1:0] occ, occ_p, lvl;
    logic infl, pop, ovf, err;
    logic [DATA_WIDTH-1:0] b0, b1, b0_n, b1_n;
    logic [CNT_WIDTH-1:0] cnt;
    always_comb begin
        pop   = (occ != 2'd0) & M_READY_i & ~FLUSH_i;
        lvl   = occ + {1'b0, infl} - {1'b0, pop};
        REN_o = ~RST_i & ~FLUSH_i & ~EMPTY_i & ~lvl[1];
        occ_p = occ - {1'b0, pop};
        // the in-flight word lands in the first free slot after this cycle's pop
        ovf   = infl & (occ_p == 2'd2);
        b0_n  = (infl && occ_p == 2'd0) ? RDATA_i : (pop ? b1 : b0);
        b1_n  = (infl && occ_p == 2'd1) ? RDATA_i : b1;
    end
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            occ  <= 2'd0;
            infl <= 1'b0;
            b0   <= '0;
            b1   <= '0;
            cnt  <= '0;
            err  <= 1'b0;
        end else begin
            occ  <= FLUSH_i ? 2'd0 : occ_p + {1'b0, infl & ~ovf};
            infl <= REN_o;
            b0   <= b0_n;
            b1   <= b1_n;
            cnt  <= cnt + CNT_WIDTH'(pop);
            err  <= err | UNDERRUN_i | (ovf & ~FLUSH_i);
        end
    end
    assign M_VALID_o  = occ != 2'd0;
    assign M_DATA_o   = b0;
    assign WORD_CNT_o = cnt;
    assign ERR_o      = err;
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed segment table plus random traffic, checked against a queue-based model.
module tb_fifo_rd_stream;
    localparam int DW = 18;
    logic CLK_i = 1'b0, RST_i = 1'b1, FLUSH_i = 1'b0, EMPTY_i = 1'b1, UNDERRUN_i = 1'b0, M_READY_i = 1'b0;
    logic [DW-1:0] RDATA_i = '0;
    logic REN_o, M_VALID_o, ERR_o;
    logic [DW-1:0] M_DATA_o;
    logic [15:0] WORD_CNT_o;
    logic ren4, valid4, err4;
    logic [DW-1:0] data4;
    logic [3:0] cnt4;

    fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
        .CLK_i(CLK_i), .RST_i(RST_i), .FLUSH_i(FLUSH_i), .EMPTY_i(EMPTY_i), .UNDERRUN_i(UNDERRUN_i),
        .RDATA_i(RDATA_i), .REN_o(REN_o), .M_VALID_o(M_VALID_o), .M_READY_i(M_READY_i),
        .M_DATA_o(M_DATA_o), .WORD_CNT_o(WORD_CNT_o), .ERR_o(ERR_o));

    fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut4 (
        .CLK_i(CLK_i), .RST_i(RST_i), .FLUSH_i(FLUSH_i), .EMPTY_i(EMPTY_i), .UNDERRUN_i(UNDERRUN_i),
        .RDATA_i(RDATA_i), .REN_o(ren4), .M_VALID_o(valid4), .M_READY_i(M_READY_i),
        .M_DATA_o(data4), .WORD_CNT_o(cnt4), .ERR_o(err4));

    always #5 CLK_i = ~CLK_i;

    int checks = 0, errors = 0;
    int fifo_q[$];
    int bq[$];
    bit pend = 1'b0, m_err = 1'b0;
    int m_cnt = 0, nxt = 1;

    typedef struct {
        int load;
        bit rst, flush, rdy, und;
        int cyc, exp_cnt;
        bit exp_err, exp_valid;
    } seg_t;
    seg_t tbl[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit flush, input bit rdy, input bit und);
        bit pop, mren, dren;
        int lvl;
        RST_i = rst; FLUSH_i = flush; M_READY_i = rdy; UNDERRUN_i = und;
        EMPTY_i = (fifo_q.size() == 0);
        @(negedge CLK_i);
        pop  = bq.size() != 0 && rdy && !flush && !rst;
        lvl  = bq.size() + int'(pend) - int'(pop);
        mren = !rst && !flush && !EMPTY_i && lvl < 2;
        check("ren", 32'(REN_o), 32'(mren));
        check("valid", 32'(M_VALID_o), 32'(bq.size() != 0));
        if (bq.size() != 0) check("data", 32'(M_DATA_o), 32'(bq[0]));
        check("cnt", 32'(WORD_CNT_o), 32'(m_cnt & 'hffff));
        check("cnt4", 32'(cnt4), 32'(m_cnt & 'hf));
        check("err", 32'(ERR_o), 32'(m_err));
        dren = REN_o;
        @(posedge CLK_i);
        #1;
        if (rst) begin
            bq.delete(); pend = 0; m_cnt = 0; m_err = 0;
        end else if (flush) begin
            bq.delete(); pend = 0; m_err = m_err | und;
        end else begin
            if (pop) begin void'(bq.pop_front()); m_cnt++; end
            if (pend) begin
                if (bq.size() < 2) bq.push_back(int'(RDATA_i));
                else m_err = 1;
            end
            pend = mren;
            m_err = m_err | und;
        end
        RDATA_i = (dren && fifo_q.size() > 0) ? DW'(fifo_q.pop_front()) : DW'($urandom);
    endtask

    initial begin
        tbl[0]  = '{0,  1, 0, 0, 0, 2,  0,  0, 0};
        tbl[1]  = '{8,  0, 0, 1, 0, 10, 8,  0, 0};
        tbl[2]  = '{6,  0, 0, 1, 0, 3,  9,  0, 1};
        tbl[3]  = '{0,  0, 0, 0, 0, 5,  9,  0, 1};
        tbl[4]  = '{0,  0, 0, 1, 0, 8,  14, 0, 0};
        tbl[5]  = '{1,  0, 0, 0, 0, 4,  14, 0, 1};
        tbl[6]  = '{0,  0, 0, 1, 0, 3,  15, 0, 0};
        tbl[7]  = '{6,  0, 0, 0, 0, 2,  15, 0, 1};
        tbl[8]  = '{0,  0, 1, 1, 0, 1,  15, 0, 0};
        tbl[9]  = '{0,  0, 0, 1, 0, 8,  19, 0, 0};
        tbl[10] = '{0,  0, 0, 1, 1, 1,  19, 1, 0};
        tbl[11] = '{0,  0, 0, 1, 0, 2,  19, 1, 0};
        tbl[12] = '{4,  0, 0, 0, 0, 3,  19, 1, 1};
        tbl[13] = '{0,  1, 1, 1, 0, 1,  0,  0, 0};
        tbl[14] = '{15, 0, 0, 1, 0, 20, 17, 0, 0};
        repeat (2) @(posedge CLK_i);
        #1;
        for (int s = 0; s < 15; s++) begin
            for (int k = 0; k < tbl[s].load; k++) fifo_q.push_back(nxt++);
            for (int c = 0; c < tbl[s].cyc; c++) step(tbl[s].rst, tbl[s].flush, tbl[s].rdy, tbl[s].und);
            check($sformatf("seg%0d_cnt", s), 32'(WORD_CNT_o), 32'(tbl[s].exp_cnt));
            check($sformatf("seg%0d_cnt4", s), 32'(cnt4), 32'(tbl[s].exp_cnt & 15));
            check($sformatf("seg%0d_err", s), 32'(ERR_o), 32'(tbl[s].exp_err));
            check($sformatf("seg%0d_valid", s), 32'(M_VALID_o), 32'(tbl[s].exp_valid));
            if (tbl[s].rst) check($sformatf("seg%0d_rst_data", s), 32'(M_DATA_o), 32'd0);
        end
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0 && fifo_q.size() < 16)
                repeat ($urandom_range(1, 3)) fifo_q.push_back(nxt++ & 'h3ffff);
            step($urandom_range(199) == 0, $urandom_range(39) == 0,
                 $urandom_range(3) != 0, $urandom_range(149) == 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
